// File: rtl/and2_eval_sched.sv
// and2_eval_sched
//   Time-multiplexed evaluator for flat and2 netlists (c = a & b). A programmable
//   gate table drives one shared AND unit. Each cycle the unit evaluates one table
//   entry, in table order, against a wire register file. Passes over the table
//   repeat until a pass leaves every wire unchanged, or until MAX_PASS passes have
//   run.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cfg_we/cfg_addr       write one gate-table entry (IDLE only)
//   cfg_en/a/b/dst        entry contents: valid flag, source wires, destination wire
//   wire_we/idx/din       force one wire of the register file (IDLE only)
//   start                 begin an evaluation run (IDLE only)
//   busy                  high while passes are evaluating or being checked
//   done                  one-cycle pulse when a run ends
//   settled               last run converged; held until the next start
//   pass_cnt              number of passes executed in the last run; held
//   wires_out             wire register file, driven directly
module and2_eval_sched #(
  parameter int NWIRES   = 5,
  parameter int NGATES   = 4,
  parameter int MAX_PASS = 4,
  localparam int IW = (NWIRES > 1) ? $clog2(NWIRES) : 1,
  localparam int GW = (NGATES > 1) ? $clog2(NGATES) : 1,
  localparam int PW = $clog2(MAX_PASS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [GW-1:0]     cfg_addr,
  input  logic              cfg_en,
  input  logic [IW-1:0]     cfg_a,
  input  logic [IW-1:0]     cfg_b,
  input  logic [IW-1:0]     cfg_dst,
  input  logic              wire_we,
  input  logic [IW-1:0]     wire_idx,
  input  logic              wire_din,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              settled,
  output logic [PW-1:0]     pass_cnt,
  output logic [NWIRES-1:0] wires_out
);

  typedef enum logic [1:0] {IDLE, EVAL, CHECK, DONE} state_t;

  state_t            state;
  logic [NWIRES-1:0] wires;
  logic              tbl_en  [NGATES];
  logic [IW-1:0]     tbl_a   [NGATES];
  logic [IW-1:0]     tbl_b   [NGATES];
  logic [IW-1:0]     tbl_dst [NGATES];
  logic [GW-1:0]     ptr;
  logic              changed;

  logic              cur_en;
  logic [IW-1:0]     cur_a;
  logic [IW-1:0]     cur_b;
  logic [IW-1:0]     cur_dst;
  logic              val_a;
  logic              val_b;
  logic              old_val;
  logic              new_val;
  logic              dst_ok;

  assign wires_out = wires;

  // Fetch the entry under ptr and read its operands. Wire lookups are done by
  // matching every legal index, so indices >= NWIRES read as 0 and a destination
  // >= NWIRES leaves dst_ok low (the write is discarded and never counts as a change).
  always_comb begin
    cur_en  = 1'b0;
    cur_a   = '0;
    cur_b   = '0;
    cur_dst = '0;
    for (int g = 0; g < NGATES; g++) begin
      if (ptr == GW'(g)) begin
        cur_en  = tbl_en[g];
        cur_a   = tbl_a[g];
        cur_b   = tbl_b[g];
        cur_dst = tbl_dst[g];
      end
    end
    val_a   = 1'b0;
    val_b   = 1'b0;
    old_val = 1'b0;
    dst_ok  = 1'b0;
    for (int i = 0; i < NWIRES; i++) begin
      if (cur_a == IW'(i)) val_a = wires[i];
      if (cur_b == IW'(i)) val_b = wires[i];
      if (cur_dst == IW'(i)) begin
        old_val = wires[i];
        dst_ok  = 1'b1;
      end
    end
    new_val = val_a & val_b;
  end

  // Sequencer, table and wire store. Configuration, wire forcing and start are
  // only honoured in IDLE; in every other state they are simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wires    <= '0;
      ptr      <= '0;
      changed  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      settled  <= 1'b0;
      pass_cnt <= '0;
      for (int g = 0; g < NGATES; g++) begin
        tbl_en[g]  <= 1'b0;
        tbl_a[g]   <= '0;
        tbl_b[g]   <= '0;
        tbl_dst[g] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cfg_we) begin
            for (int g = 0; g < NGATES; g++) begin
              if (cfg_addr == GW'(g)) begin
                tbl_en[g]  <= cfg_en;
                tbl_a[g]   <= cfg_a;
                tbl_b[g]   <= cfg_b;
                tbl_dst[g] <= cfg_dst;
              end
            end
          end
          if (wire_we) begin
            for (int i = 0; i < NWIRES; i++) begin
              if (wire_idx == IW'(i)) wires[i] <= wire_din;
            end
          end
          if (start) begin
            state    <= EVAL;
            busy     <= 1'b1;
            ptr      <= '0;
            pass_cnt <= PW'(1);
            changed  <= 1'b0;
            settled  <= 1'b0;
          end
        end

        EVAL: begin
          // Operands come from register values at cycle start, so dst==a or
          // dst==b is safe and a later entry to the same dst overwrites this one.
          if (cur_en && dst_ok) begin
            for (int i = 0; i < NWIRES; i++) begin
              if (cur_dst == IW'(i)) wires[i] <= new_val;
            end
            if (new_val != old_val) changed <= 1'b1;
          end
          if (ptr == GW'(NGATES - 1)) begin
            state <= CHECK;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end

        CHECK: begin
          if (!changed) begin
            settled <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (pass_cnt == PW'(MAX_PASS)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
            changed  <= 1'b0;
            ptr      <= '0;
            state    <= EVAL;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
